fifo_rd_stream: RTL

Read-side drain engine for the async FIFO. It lives in the rclk domain, between the read-pointer/empty logic with its memory read port and a downstream valid/ready consumer. It issues FIFO read enables, absorbs the memory's 1-cycle read latency with a 2-entry skid buffer, and presents an ordered, loss-free stream with full one-word-per-cycle throughput.

---
 rtl/fifo_rd_stream_if.sv | 39 +++
 rtl/fifo_rd_stream.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
//==============================================================================
// Module      : fifo_rd_stream_if
// Description : FIFO read-port and downstream valid/ready stream signals.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  r_en;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    // Environment side: FIFO pointer/memory logic plus the stream consumer.
    modport master (
        output empty,
        output rdata,
        output m_ready,
        input  r_en,
        input  m_valid,
        input  m_data
    );

    // Drain-engine side.
    modport slave (
        input  empty,
        input  rdata,
        input  m_ready,
        output r_en,
        output m_valid,
        output m_data
    );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
//==============================================================================
// Module      : fifo_rd_stream
// Description : Read-side drain engine; 2-entry skid buffer over a 1-cycle
//               latency FIFO read port. Optional macro FIFO_RD_LEVEL_EN adds
//               a registered read-side fill level output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  wire logic               rclk,
    input  wire logic               rrst_n,
`ifdef FIFO_RD_LEVEL_EN
    input  wire logic [PTR_WIDTH:0] g_wptr_sync,
    input  wire logic [PTR_WIDTH:0] b_rptr,
    output logic      [PTR_WIDTH:0] rlevel,
`endif
    fifo_rd_stream_if.slave         io_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HALF = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rd_pend;
    logic                  r_m_valid;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_fire;
    logic                  w_slot1;
    logic [1:0]            w_occ;
    logic [2:0]            w_credit;

    assign w_push = r_rd_pend;
    assign w_pop  = r_m_valid & io_bus.m_ready;

    always_comb begin
        w_occ = 2'd0;
        case (r_state)
            S_HALF:  w_occ = 2'd1;
            S_FULL:  w_occ = 2'd2;
            default: w_occ = 2'd0;
        endcase
    end

    // Words already owned (buffered or in flight) after this cycle's pop.
    // m_ready feeds r_en combinationally so a full buffer can refill on pop.
    assign w_credit  = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_rd_fire = rrst_n & ~io_bus.empty & (w_credit < 3'd2);

    assign io_bus.r_en    = w_rd_fire;
    assign io_bus.m_valid = r_m_valid;
    assign io_bus.m_data  = r_buf0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_push && !w_pop) w_state_nxt = S_HALF;
            S_HALF: begin
                if (w_push && !w_pop)      w_state_nxt = S_FULL;
                else if (w_pop && !w_push) w_state_nxt = S_IDLE;
            end
            S_FULL: if (w_pop && !w_push) w_state_nxt = S_HALF;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state   <= S_IDLE;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_m_valid <= (w_state_nxt != S_IDLE);
        end
    end

    // Incoming word lands in the first free slot once this cycle's pop is applied.
    assign w_slot1 = (w_occ == 2'd2) || ((w_occ == 2'd1) && !w_pop);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rd_pend <= 1'b0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            r_rd_pend <= w_rd_fire;
            if (w_pop && (w_occ == 2'd2)) begin
                r_buf0 <= r_buf1;
            end
            if (w_push) begin
                if (w_slot1) r_buf1 <= io_bus.rdata;
                else         r_buf0 <= io_bus.rdata;
            end
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
        logic [PTR_WIDTH:0] b;
        b = '0;
        for (int i = 0; i <= PTR_WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [PTR_WIDTH:0] r_rlevel;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) r_rlevel <= '0;
        else         r_rlevel <= gray2bin(g_wptr_sync) - b_rptr;
    end

    assign rlevel = r_rlevel;
`endif

endmodule

`default_nettype wire
